// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard-detection and flush controller for a non-forwarding in-order
// five-stage pipeline. A shift-register scoreboard tracks the destination
// registers of in-flight instructions (slot 0 = EX, slot 1 = MEM, ...).
// Source reads in ID are checked against it to generate stalls. Redirects
// flush the wrong-path stages, and freeze holds the whole pipeline.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_id_valid                ID holds a real instruction
//   i_id_rs1/rs2, use_rs1/2   ID source registers and their read enables
//   i_id_rd, i_id_rdwren      ID destination register and its write enable
//   i_redirect                instruction in REDIRECT_SLOT changes the PC
//   i_freeze                  multi-cycle EX busy, whole pipeline holds
//   o_pc_wren, o_ifid_wren    PC and IF/ID write enables
//   o_hold                    hold for all registers downstream of ID
//   o_clear[DEPTH:0]          bit i clears the register feeding stage i
//   o_stall_cnt, o_flush_cnt  saturating performance counters
module hazard_scoreboard #(
  parameter int DEPTH         = 3,
  parameter int REDIRECT_SLOT = 1,
  parameter int RF_BYPASS     = 0,
  parameter int CNT_W         = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_rdwren,
  input  logic             i_redirect,
  input  logic             i_freeze,
  output logic             o_pc_wren,
  output logic             o_ifid_wren,
  output logic             o_hold,
  output logic [DEPTH:0]   o_clear,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // A write-through register file serves the oldest slot's value to ID
  // directly, so that slot need not block.
  localparam int NCHK = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  typedef enum logic [2:0] {
    M_RESET,
    M_FREEZE,
    M_REDIRECT,
    M_STALL,
    M_ISSUE
  } mode_e;

  logic [DEPTH-1:0]      vld_q, vld_d, vld_sh;
  logic [DEPTH-1:0][4:0] rd_q, rd_d, rd_sh;
  logic [CNT_W-1:0]      stall_q, stall_d, flush_q, flush_d;
  logic                  hit_rs1, hit_rs2, hazard;
  mode_e                 mode;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < NCHK && vld_q[k] && rd_q[k] != 5'd0) begin
        if (rd_q[k] == i_id_rs1) hit_rs1 = 1'b1;
        if (rd_q[k] == i_id_rs2) hit_rs2 = 1'b1;
      end
    end
    hazard = i_id_valid &
             ((i_id_use_rs1 & (i_id_rs1 != 5'd0) & hit_rs1) |
              (i_id_use_rs2 & (i_id_rs2 != 5'd0) & hit_rs2));
  end

  always_comb begin
    if (!i_rst_n)        mode = M_RESET;
    else if (i_freeze)   mode = M_FREEZE;
    else if (i_redirect) mode = M_REDIRECT;
    else if (hazard)     mode = M_STALL;
    else                 mode = M_ISSUE;
  end

  // Scoreboard advanced by one stage with an empty slot 0.
  always_comb begin
    vld_sh    = '0;
    rd_sh     = '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_sh[k] = vld_q[k-1];
      rd_sh[k]  = rd_q[k-1];
    end
  end

  always_comb begin
    o_pc_wren   = 1'b0;
    o_ifid_wren = 1'b0;
    o_hold      = 1'b0;
    o_clear     = '0;
    vld_d       = vld_q;
    rd_d        = rd_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    case (mode)
      M_RESET: begin
        o_clear = '1;
      end
      M_FREEZE: begin
        o_hold = 1'b1;
      end
      M_REDIRECT: begin
        o_pc_wren   = 1'b1;
        o_ifid_wren = 1'b1;
        for (int i = 0; i <= DEPTH; i++) o_clear[i] = (i <= REDIRECT_SLOT + 1);
        vld_d = vld_sh;
        rd_d  = rd_sh;
        // Everything younger than the redirecting instruction is wrong path;
        // the redirecting instruction itself lands in REDIRECT_SLOT+1.
        for (int k = 0; k < DEPTH; k++) if (k <= REDIRECT_SLOT) vld_d[k] = 1'b0;
        if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
      end
      M_STALL: begin
        o_clear[1] = 1'b1;
        vld_d      = vld_sh;
        rd_d       = rd_sh;
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
      end
      default: begin
        o_pc_wren   = 1'b1;
        o_ifid_wren = 1'b1;
        vld_d       = vld_sh;
        rd_d        = rd_sh;
        vld_d[0]    = i_id_valid & i_id_rdwren & (i_id_rd != 5'd0);
        rd_d[0]     = i_id_rd;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q   <= '0;
      rd_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int RSLOT = 1;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, use1, use2, rdwren, redirect, freeze;
  logic [4:0] rs1, rs2, rd;

  logic        a_pc, a_ifid, a_hold, b_pc, b_ifid, b_hold;
  logic [3:0]  a_clear, b_clear;
  logic [31:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;

  int nassert = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .REDIRECT_SLOT(RSLOT), .RF_BYPASS(0), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_rd(rd), .i_id_rdwren(rdwren), .i_redirect(redirect), .i_freeze(freeze),
    .o_pc_wren(a_pc), .o_ifid_wren(a_ifid), .o_hold(a_hold), .o_clear(a_clear),
    .o_stall_cnt(a_stall), .o_flush_cnt(a_flush));

  hazard_scoreboard #(.DEPTH(3), .REDIRECT_SLOT(RSLOT), .RF_BYPASS(1), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_rd(rd), .i_id_rdwren(rdwren), .i_redirect(redirect), .i_freeze(freeze),
    .o_pc_wren(b_pc), .o_ifid_wren(b_ifid), .o_hold(b_hold), .o_clear(b_clear),
    .o_stall_cnt(b_stall), .o_flush_cnt(b_flush));

  // Reference model: a list of in-flight writers, each with the number of
  // pipeline advances since it issued. Instance 0 = dut_a, 1 = dut_b.
  typedef struct {
    int inst;
    int rd;
    int age;
  } ent_t;

  ent_t   flight[$];
  int     depth_m[2] = '{3, 3};
  int     nchk_m[2]  = '{3, 2};
  longint cmax_m[2]  = '{64'hFFFF_FFFF, 64'd15};
  longint stall_m[2] = '{0, 0};
  longint flush_m[2] = '{0, 0};

  function automatic bit m_busy(int inst, int src);
    foreach (flight[i])
      if (flight[i].inst == inst && flight[i].age < nchk_m[inst] && flight[i].rd == src)
        return 1'b1;
    return 1'b0;
  endfunction

  // 0 reset, 1 freeze, 2 redirect, 3 stall, 4 issue
  function automatic int m_mode(int inst);
    bit haz;
    haz = id_valid && ((use1 && rs1 != 0 && m_busy(inst, int'(rs1))) ||
                       (use2 && rs2 != 0 && m_busy(inst, int'(rs2))));
    if (!rst_n)   return 0;
    if (freeze)   return 1;
    if (redirect) return 2;
    if (haz)      return 3;
    return 4;
  endfunction

  // Expected {pc_wren, ifid_wren, hold, clear[3:0]}
  function automatic logic [6:0] m_outs(int md);
    int redir_mask;
    redir_mask = (1 << (RSLOT + 2)) - 1;
    case (md)
      0:       return 7'b000_1111;
      1:       return 7'b001_0000;
      2:       return {3'b110, 4'(redir_mask)};
      3:       return 7'b000_0010;
      default: return 7'b110_0000;
    endcase
  endfunction

  task automatic m_advance(int inst, int md);
    ent_t nq[$];
    ent_t e;
    foreach (flight[i]) begin
      e = flight[i];
      if (e.inst != inst) nq.push_back(e);
      else if (md == 1) nq.push_back(e);
      else if (md != 0) begin
        e.age++;
        if (e.age < depth_m[inst] && !(md == 2 && e.age <= RSLOT)) nq.push_back(e);
      end
    end
    if (md == 4 && id_valid && rdwren && rd != 0) begin
      e.inst = inst; e.rd = int'(rd); e.age = 0;
      nq.push_back(e);
    end
    flight = nq;
    if (md == 0) begin
      stall_m[inst] = 0;
      flush_m[inst] = 0;
    end
    if (md == 2 && flush_m[inst] < cmax_m[inst]) flush_m[inst]++;
    if (md == 3 && stall_m[inst] < cmax_m[inst]) stall_m[inst]++;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nassert++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the new inputs already applied.
  task automatic tick();
    int md[2];
    logic [6:0] ex[2];
    for (int i = 0; i < 2; i++) begin
      md[i] = m_mode(i);
      ex[i] = m_outs(md[i]);
    end
    @(negedge clk);
    chk("outs_a", 64'({a_pc, a_ifid, a_hold, a_clear}), 64'(ex[0]));
    chk("outs_b", 64'({b_pc, b_ifid, b_hold, b_clear}), 64'(ex[1]));
    @(posedge clk);
    m_advance(0, md[0]);
    m_advance(1, md[1]);
    #1;
    chk("stall_a", 64'(a_stall), 64'(stall_m[0]));
    chk("flush_a", 64'(a_flush), 64'(flush_m[0]));
    chk("stall_b", 64'(b_stall), 64'(stall_m[1]));
    chk("flush_b", 64'(b_flush), 64'(flush_m[1]));
  endtask

  task automatic set_id(logic v, logic [4:0] s1, logic u1, logic [4:0] s2, logic u2,
                        logic [4:0] d, logic w);
    id_valid = v; rs1 = s1; use1 = u1; rs2 = s2; use2 = u2; rd = d; rdwren = w;
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] snap_a;
    logic [3:0]  snap_b;

    rst_n = 1'b0; redirect = 1'b0; freeze = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // back-to-back dependency through x5
    set_id(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1);
    repeat (4) tick();
    chk("dep_stall_a", 64'(a_stall), 64'd3);
    chk("dep_stall_b", 64'(b_stall), 64'd2);
    idle(4);

    // branch in slot 1, lw x7 in slot 0, then redirect
    set_id(1, 1, 1, 2, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 7, 1);
    tick();
    redirect = 1'b1;
    set_id(1, 8, 1, 0, 0, 9, 1);
    tick();
    redirect = 1'b0;
    set_id(1, 7, 1, 7, 1, 10, 1);
    tick();
    chk("redir_flush_a", 64'(a_flush), 64'd1);
    chk("redir_nostall_a", 64'(a_stall), 64'd3);
    idle(4);

    // dependency stall with a 5-cycle freeze in the middle
    snap_a = a_stall;
    snap_b = b_stall;
    set_id(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1);
    tick();
    freeze = 1'b1;
    repeat (5) tick();
    freeze = 1'b0;
    repeat (3) tick();
    chk("freeze_stall_a", 64'(a_stall - snap_a), 64'd3);
    chk("freeze_stall_b", 64'(b_stall - snap_b), 64'd2);
    idle(4);

    // x0 producer and unused matching sources
    snap_a = a_stall;
    set_id(1, 0, 0, 0, 0, 0, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 11, 1);
    tick();
    set_id(1, 3, 1, 11, 0, 12, 1);
    tick();
    set_id(1, 12, 0, 4, 1, 13, 1);
    tick();
    chk("x0_unused_a", 64'(a_stall - snap_a), 64'd0);
    idle(4);

    // push dut_b's 4-bit stall counter into saturation
    repeat (10) begin
      set_id(1, 0, 0, 0, 0, 9, 1);
      tick();
      set_id(1, 9, 1, 0, 0, 14, 1);
      repeat (3) tick();
    end
    chk("sat_stall_b", 64'(b_stall), 64'd15);

    // reset in the middle of a stall
    set_id(1, 0, 0, 0, 0, 9, 1);
    tick();
    set_id(1, 9, 1, 9, 1, 15, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_stall_a", 64'(a_stall), 64'd0);
    chk("rst_flush_a", 64'(a_flush), 64'd0);
    chk("rst_stall_b", 64'(b_stall), 64'd0);
    tick();
    chk("post_rst_free_a", 64'(a_stall), 64'd0);
    idle(2);

    // randomized traffic over a small register set to provoke hazards
    repeat (500) begin
      rst_n    = ($urandom % 64) != 0;
      freeze   = ($urandom % 8) == 0;
      redirect = ($urandom % 10) == 0;
      id_valid = ($urandom % 5) != 0;
      rs1      = 5'($urandom % 4);
      rs2      = 5'($urandom % 4);
      use1     = $urandom % 2;
      use2     = $urandom % 2;
      rd       = 5'($urandom % 4);
      rdwren   = id_valid && ($urandom % 4 != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
